// File: rtl/axi_mem_if_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_if_slave
// Purpose  : AXI4 slave to synchronous SRAM bridge. Each AXI beat is turned
//            into one request on a req/we/addr/be/wdata/rdata memory port.
//            Handles one transaction at a time and always answers OKAY.
//            Beat addresses follow FIXED/INCR/WRAP burst rules.
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_if_slave #(
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_USER_WIDTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // AW channel
  input  logic                        aw_valid,
  output logic                        aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id,
  input  logic [7:0]                  aw_len,
  input  logic [2:0]                  aw_size,
  input  logic [1:0]                  aw_burst,
  input  logic [3:0]                  aw_cache,
  input  logic [2:0]                  aw_prot,
  // W channel
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  input  logic                        w_last,
  // B channel
  output logic                        b_valid,
  input  logic                        b_ready,
  output logic [AXI_ID_WIDTH-1:0]     b_id,
  output logic [1:0]                  b_resp,
  // AR channel
  input  logic                        ar_valid,
  output logic                        ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id,
  input  logic [7:0]                  ar_len,
  input  logic [2:0]                  ar_size,
  input  logic [1:0]                  ar_burst,
  input  logic [3:0]                  ar_cache,
  input  logic [2:0]                  ar_prot,
  // R channel
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [AXI_DATA_WIDTH-1:0]   r_data,
  output logic [AXI_ID_WIDTH-1:0]     r_id,
  output logic [1:0]                  r_resp,
  output logic                        r_last,
  // Memory port
  output logic                        req_o,
  output logic                        we_o,
  output logic [AXI_ADDR_WIDTH-1:0]   addr_o,
  output logic [AXI_DATA_WIDTH/8-1:0] be_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_o,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i
);

  localparam logic [AXI_ADDR_WIDTH-1:0] c_ADDR_ONE = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_BRESP = 2'd3
  } state_t;

  state_t                      r_state;
  logic [AXI_ID_WIDTH-1:0]     r_txn_id;
  logic [AXI_ADDR_WIDTH-1:0]   r_txn_addr;
  logic [7:0]                  r_txn_len;
  logic [2:0]                  r_txn_size;
  logic [1:0]                  r_txn_burst;
  logic [7:0]                  r_beat_cnt;
  logic                        r_rd_vld;

  logic [AXI_ADDR_WIDTH-1:0]   w_step;
  logic [AXI_ADDR_WIDTH-1:0]   w_aligned;
  logic [AXI_ADDR_WIDTH-1:0]   w_wrap_bytes;
  logic [AXI_ADDR_WIDTH-1:0]   w_next_addr;
  logic                        w_last_beat;
  logic                        w_r_hs;
  logic                        w_unused;

  // Control and attribute inputs this bridge has no use for.
  assign w_unused = ^{aw_cache, aw_prot, ar_cache, ar_prot, w_last};

  assign w_last_beat = (r_beat_cnt == r_txn_len);
  assign w_r_hs      = r_rd_vld & r_ready;

  // Channel handshakes are pure state decodes; ready is held low in reset.
  assign ar_ready = rst_ni & (r_state == S_IDLE);
  assign aw_ready = rst_ni & (r_state == S_IDLE) & ~ar_valid;
  assign w_ready  = (r_state == S_WRITE);
  assign b_valid  = (r_state == S_BRESP);
  assign b_id     = r_txn_id;
  assign b_resp   = 2'b00;
  assign r_valid  = r_rd_vld;
  assign r_data   = data_i;
  assign r_id     = r_txn_id;
  assign r_resp   = 2'b00;
  assign r_last   = r_rd_vld & w_last_beat;

  // Beat address generator: address of the beat after the current one.
  always_comb begin
    w_step       = c_ADDR_ONE << r_txn_size;
    w_aligned    = r_txn_addr & ~(w_step - c_ADDR_ONE);
    w_wrap_bytes = (AXI_ADDR_WIDTH'(r_txn_len) + c_ADDR_ONE) << r_txn_size;
    case (r_txn_burst)
      2'b00:   w_next_addr = r_txn_addr;
      2'b10:   w_next_addr = (r_txn_addr & ~(w_wrap_bytes - c_ADDR_ONE)) |
                             ((w_aligned + w_step) & (w_wrap_bytes - c_ADDR_ONE));
      default: w_next_addr = w_aligned + w_step;
    endcase
  end

  // Memory port drive: reads look ahead on an R handshake so beats stream
  // back to back; a stalled read re-requests the same address so data_i holds.
  always_comb begin
    req_o  = 1'b0;
    we_o   = 1'b0;
    addr_o = '0;
    be_o   = '0;
    data_o = '0;
    case (r_state)
      S_READ: begin
        if (!(w_r_hs && w_last_beat)) begin
          req_o  = 1'b1;
          be_o   = '1;
          addr_o = w_r_hs ? w_next_addr : r_txn_addr;
        end
      end
      S_WRITE: begin
        if (w_valid) begin
          req_o  = 1'b1;
          we_o   = 1'b1;
          addr_o = r_txn_addr;
          be_o   = w_strb;
          data_o = w_data;
        end
      end
      default: ;
    endcase
  end

  // Transaction FSM with latched burst attributes and beat tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_txn_id    <= '0;
      r_txn_addr  <= '0;
      r_txn_len   <= '0;
      r_txn_size  <= '0;
      r_txn_burst <= '0;
      r_beat_cnt  <= '0;
      r_rd_vld    <= 1'b0;
    end else begin
      r_rd_vld <= (r_state == S_READ) && req_o;
      case (r_state)
        S_IDLE: begin
          if (ar_valid) begin
            r_txn_id    <= ar_id;
            r_txn_addr  <= ar_addr;
            r_txn_len   <= ar_len;
            r_txn_size  <= ar_size;
            r_txn_burst <= ar_burst;
            r_beat_cnt  <= '0;
            r_state     <= S_READ;
          end else if (aw_valid) begin
            r_txn_id    <= aw_id;
            r_txn_addr  <= aw_addr;
            r_txn_len   <= aw_len;
            r_txn_size  <= aw_size;
            r_txn_burst <= aw_burst;
            r_beat_cnt  <= '0;
            r_state     <= S_WRITE;
          end
        end
        S_READ: begin
          if (w_r_hs) begin
            if (w_last_beat) begin
              r_state <= S_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
              r_txn_addr <= w_next_addr;
            end
          end
        end
        S_WRITE: begin
          if (w_valid) begin
            if (w_last_beat) begin
              r_state <= S_BRESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
              r_txn_addr <= w_next_addr;
            end
          end
        end
        S_BRESP: begin
          if (b_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_if_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_if_slave
// Purpose  : Self-checking bench for axi_mem_if_slave with an SRAM model and
//            queue scoreboards for memory requests, R beats and B responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_if_slave;

  localparam int IDW = 8;
  localparam int AW  = 40;
  localparam int DW  = 128;
  localparam int SW  = DW / 8;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           aw_valid, aw_ready;
  logic [AW-1:0]  aw_addr;
  logic [IDW-1:0] aw_id;
  logic [7:0]     aw_len;
  logic [2:0]     aw_size;
  logic [1:0]     aw_burst;
  logic [3:0]     aw_cache;
  logic [2:0]     aw_prot;
  logic           w_valid, w_ready, w_last;
  logic [DW-1:0]  w_data;
  logic [SW-1:0]  w_strb;
  logic           b_valid, b_ready;
  logic [IDW-1:0] b_id;
  logic [1:0]     b_resp;
  logic           ar_valid, ar_ready;
  logic [AW-1:0]  ar_addr;
  logic [IDW-1:0] ar_id;
  logic [7:0]     ar_len;
  logic [2:0]     ar_size;
  logic [1:0]     ar_burst;
  logic [3:0]     ar_cache;
  logic [2:0]     ar_prot;
  logic           r_valid, r_ready, r_last;
  logic [DW-1:0]  r_data;
  logic [IDW-1:0] r_id;
  logic [1:0]     r_resp;
  logic           req_o, we_o;
  logic [AW-1:0]  addr_o;
  logic [SW-1:0]  be_o;
  logic [DW-1:0]  data_o;
  logic [DW-1:0]  data_i = '0;

  int checks = 0;
  int errors = 0;
  int rbeats = 0;

  typedef struct packed { logic [AW-1:0] addr; logic [SW-1:0] be; logic [DW-1:0] data; } wexp_t;
  typedef struct packed { logic [DW-1:0] data; logic last; logic [IDW-1:0] id; } rexp_t;

  wexp_t          wq[$];
  rexp_t          rq[$];
  logic [AW-1:0]  raq[$];
  logic [IDW-1:0] bq[$];

  always #5 clk_i = ~clk_i;

  axi_mem_if_slave #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache), .aw_prot(aw_prot),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache), .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_resp(r_resp), .r_last(r_last),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o), .data_o(data_o), .data_i(data_i)
  );

  // SRAM model: unwritten words return an address-derived pattern.
  bit            written [4096];
  logic [DW-1:0] wmem    [4096];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [31:0] x;
    x = a[31:0] & 32'hFFFF_FFF0;
    return {x ^ 32'hA5A5_0000, ~x, x + 32'd1, 32'hC0DE_0000 | x};
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (written[a[15:4]]) return wmem[a[15:4]];
    return pat(a);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] be);
    logic [DW-1:0] v;
    v = old;
    for (int i = 0; i < SW; i++) if (be[i]) v[8*i +: 8] = nw[8*i +: 8];
    return v;
  endfunction

  always @(posedge clk_i) begin
    if (req_o) begin
      if (we_o) begin
        wmem[addr_o[15:4]]    <= merge(mem_rd(addr_o), data_o, be_o);
        written[addr_o[15:4]] <= 1'b1;
      end else begin
        data_i <= mem_rd(addr_o);
      end
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed no/unexpected event expected scoreboard match", tag);
  endtask

  // Monitor: compares DUT activity against the scoreboard queues.
  wexp_t         mon_w;
  rexp_t         mon_r;
  logic [AW-1:0] mon_a;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (req_o && we_o) begin
        if (wq.size() == 0) fail("unexpected_write");
        else begin
          mon_w = wq.pop_front();
          check("wr_addr", DW'(addr_o), DW'(mon_w.addr));
          check("wr_be", DW'(be_o), DW'(mon_w.be));
          check("wr_data", data_o, mon_w.data);
        end
      end
      if (req_o && !we_o) begin
        check("rd_be", DW'(be_o), DW'({SW{1'b1}}));
        if (raq.size() > 0) begin
          mon_a = raq.pop_front();
          check("rd_addr", DW'(addr_o), DW'(mon_a));
        end
      end
      if (r_valid && stall_prev) check("r_data_stable", r_data, stall_data);
      stall_prev <= r_valid && !r_ready;
      stall_data <= r_data;
      if (r_valid && r_ready) begin
        rbeats++;
        if (rq.size() == 0) fail("unexpected_r");
        else begin
          mon_r = rq.pop_front();
          check("r_data", r_data, mon_r.data);
          check("r_last", DW'(r_last), DW'(mon_r.last));
          check("r_id", DW'(r_id), DW'(mon_r.id));
          check("r_resp", DW'(r_resp), DW'(2'b00));
        end
      end
      if (b_valid && b_ready) begin
        if (bq.size() == 0) fail("unexpected_b");
        else begin
          check("b_id", DW'(b_id), DW'(bq.pop_front()));
          check("b_resp", DW'(b_resp), DW'(2'b00));
        end
      end
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic do_ar(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int k;
    ar_valid = 1'b1; ar_id = id; ar_addr = a; ar_len = len; ar_size = size; ar_burst = burst;
    k = 0;
    @(negedge clk_i);
    while (!ar_ready && k < 50) begin @(negedge clk_i); k++; end
    if (!ar_ready) fail("ar_timeout");
    @(posedge clk_i); #1;
    ar_valid = 1'b0;
  endtask

  task automatic do_aw(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int k;
    aw_valid = 1'b1; aw_id = id; aw_addr = a; aw_len = len; aw_size = size; aw_burst = burst;
    k = 0;
    @(negedge clk_i);
    while (!aw_ready && k < 50) begin @(negedge clk_i); k++; end
    if (!aw_ready) fail("aw_timeout");
    @(posedge clk_i); #1;
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input int n, input logic [DW-1:0] base, input logic [SW-1:0] strb);
    int k;
    for (int i = 0; i < n; i++) begin
      w_valid = 1'b1; w_data = base + DW'(i); w_strb = strb; w_last = (i == n - 1);
      k = 0;
      @(negedge clk_i);
      while (!w_ready && k < 50) begin @(negedge clk_i); k++; end
      if (!w_ready) fail("w_timeout");
      @(posedge clk_i); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k;
    k = 0;
    while ((wq.size() + rq.size() + raq.size() + bq.size()) != 0 && k < max) begin
      @(posedge clk_i); #1; k++;
    end
    if ((wq.size() + rq.size() + raq.size() + bq.size()) != 0) fail("scoreboard_drain");
    @(posedge clk_i); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ar_ready"}, DW'(ar_ready), '0);
    check({tag, "_aw_ready"}, DW'(aw_ready), '0);
    check({tag, "_r_valid"}, DW'(r_valid), '0);
    check({tag, "_b_valid"}, DW'(b_valid), '0);
    check({tag, "_w_ready"}, DW'(w_ready), '0);
    check({tag, "_req"}, DW'(req_o), '0);
    check({tag, "_we"}, DW'(we_o), '0);
  endtask

  logic [DW-1:0] d_a, d_e, d_f, d_g;
  logic [AW-1:0] a;
  int            start_beats;

  initial begin
    aw_valid = 0; aw_addr = '0; aw_id = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    aw_cache = 4'h3; aw_prot = 3'h0;
    w_valid = 0; w_data = '0; w_strb = '0; w_last = 0;
    ar_valid = 0; ar_addr = '0; ar_id = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
    ar_cache = 4'h3; ar_prot = 3'h0;
    b_ready = 1; r_ready = 1;
    d_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d_e = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d_f = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
    d_g = 128'h5A5A_5A5A_A5A5_A5A5_0F0F_0F0F_F0F0_F0F0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_idle_outputs("reset");
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single-beat write then read back.
    wq.push_back('{addr: 40'h1000, be: 16'hFFFF, data: d_a});
    bq.push_back(8'h11);
    do_aw(8'h11, 40'h1000, 8'd0, 3'd4, 2'b01);
    send_w(1, d_a, 16'hFFFF);
    @(negedge clk_i);
    check("b_after_last_beat", DW'(b_valid), DW'(1'b1));
    @(posedge clk_i); #1;
    wait_done(50);
    raq.push_back(40'h1000);
    rq.push_back('{data: d_a, last: 1'b1, id: 8'h22});
    do_ar(8'h22, 40'h1000, 8'd0, 3'd4, 2'b01);
    wait_done(50);

    // INCR burst: latency and back-to-back beats.
    for (int i = 0; i < 4; i++) begin
      a = 40'h2000 + AW'(16 * i);
      raq.push_back(a);
      rq.push_back('{data: pat(a), last: (i == 3), id: 8'h7E});
    end
    do_ar(8'h7E, 40'h2000, 8'd3, 3'd4, 2'b01);
    @(negedge clk_i);
    check("rd_req_first_cycle", DW'(req_o), DW'(1'b1));
    check("rd_no_data_first_cycle", DW'(r_valid), '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("rd_stream_valid", DW'(r_valid), DW'(1'b1));
    end
    @(negedge clk_i);
    check("rd_stream_end", DW'(r_valid), '0);
    check("ar_ready_after_last", DW'(ar_ready), DW'(1'b1));
    @(posedge clk_i); #1;
    wait_done(50);

    // WRAP burst.
    raq.push_back(40'h3030); raq.push_back(40'h3000); raq.push_back(40'h3010); raq.push_back(40'h3020);
    rq.push_back('{data: pat(40'h3030), last: 1'b0, id: 8'h05});
    rq.push_back('{data: pat(40'h3000), last: 1'b0, id: 8'h05});
    rq.push_back('{data: pat(40'h3010), last: 1'b0, id: 8'h05});
    rq.push_back('{data: pat(40'h3020), last: 1'b1, id: 8'h05});
    do_ar(8'h05, 40'h3030, 8'd3, 3'd4, 2'b10);
    wait_done(50);

    // INCR burst with r_ready toggling.
    for (int i = 0; i < 4; i++) begin
      a = 40'h5000 + AW'(16 * i);
      rq.push_back('{data: pat(a), last: (i == 3), id: 8'hA0});
    end
    start_beats = rbeats;
    r_ready = 1'b0;
    do_ar(8'hA0, 40'h5000, 8'd3, 3'd4, 2'b01);
    for (int k = 0; k < 60 && rq.size() != 0; k++) begin
      @(posedge clk_i); #1;
      r_ready = ~r_ready;
    end
    r_ready = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("stall_beat_count", DW'(rbeats - start_beats), DW'(4));
    wait_done(50);

    // Simultaneous AR and AW: read wins, write follows with partial strobes.
    raq.push_back(40'h6000);
    rq.push_back('{data: pat(40'h6000), last: 1'b1, id: 8'h33});
    wq.push_back('{addr: 40'h4000, be: 16'h00FF, data: d_e});
    wq.push_back('{addr: 40'h4010, be: 16'h00FF, data: d_e + 128'd1});
    bq.push_back(8'h44);
    aw_valid = 1'b1; aw_id = 8'h44; aw_addr = 40'h4000; aw_len = 8'd1; aw_size = 3'd4; aw_burst = 2'b01;
    ar_valid = 1'b1; ar_id = 8'h33; ar_addr = 40'h6000; ar_len = 8'd0; ar_size = 3'd4; ar_burst = 2'b01;
    @(negedge clk_i);
    check("arb_ar_ready", DW'(ar_ready), DW'(1'b1));
    check("arb_aw_blocked", DW'(aw_ready), '0);
    @(posedge clk_i); #1;
    ar_valid = 1'b0;
    begin
      int k;
      k = 0;
      @(negedge clk_i);
      while (!aw_ready && k < 50) begin @(negedge clk_i); k++; end
      if (!aw_ready) fail("arb_aw_timeout");
      check("arb_read_first", DW'(rq.size()), '0);
    end
    @(posedge clk_i); #1;
    aw_valid = 1'b0;
    send_w(2, d_e, 16'h00FF);
    wait_done(50);

    // Reset during beat 2 of a 4-beat write.
    wq.push_back('{addr: 40'h7000, be: 16'hFFFF, data: d_f});
    wq.push_back('{addr: 40'h7010, be: 16'hFFFF, data: d_f + 128'd1});
    do_aw(8'h55, 40'h7000, 8'd3, 3'd4, 2'b01);
    send_w(2, d_f, 16'hFFFF);
    w_valid = 1'b1; w_data = d_f + 128'd2; w_strb = 16'hFFFF;
    #2;
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("midreset");
    w_valid = 1'b0;
    check("midreset_queues_drained", DW'(wq.size()), '0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    wq.push_back('{addr: 40'h7000, be: 16'hFFFF, data: d_g});
    bq.push_back(8'h66);
    do_aw(8'h66, 40'h7000, 8'd0, 3'd4, 2'b01);
    send_w(1, d_g, 16'hFFFF);
    wait_done(50);
    raq.push_back(40'h7000);
    rq.push_back('{data: d_g, last: 1'b1, id: 8'h77});
    do_ar(8'h77, 40'h7000, 8'd0, 3'd4, 2'b01);
    wait_done(50);

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
